// File: rtl/ghost_sd_pkg.sv
// Shared types and defaults for the SD keystream path: bank lifecycle states,
// default geometry and a pointer-width helper.
package ghost_sd_pkg;

    typedef enum logic [1:0] {
        BANK_EMPTY    = 2'd0,
        BANK_FILLING  = 2'd1,
        BANK_READY    = 2'd2,
        BANK_DRAINING = 2'd3
    } bank_state_e;

    localparam int DEFAULT_DW     = 4;
    localparam int DEFAULT_DEPTH  = 1024;
    localparam int DEFAULT_NBANKS = 2;

    // A single-entry space still needs one address bit to stay a legal vector.
    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sdp_ram.sv
// Simple dual-port synchronous RAM: one write port, one registered read port.
// Contents are never reset; the owner tracks which entries are valid.
module sdp_ram
    import ghost_sd_pkg::*;
#(
    parameter int DW = DEFAULT_DW,
    parameter int AW = ptr_width(DEFAULT_DEPTH) + ptr_width(DEFAULT_NBANKS)
) (
    input  logic          i_clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [DW-1:0] i_wdata,
    input  logic          i_re,
    input  logic [AW-1:0] i_raddr,
    output logic [DW-1:0] o_rdata
);

    logic [DW-1:0] r_mem [2**AW];
    logic [DW-1:0] r_rdata;

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/otp_stream_buffer.sv
// Multi-bank one-time-pad buffer: the generator fills banks in order while the
// SD side XORs raw words against the oldest READY bank, optionally keeping it.
module otp_stream_buffer
    import ghost_sd_pkg::*;
#(
    parameter int DW     = DEFAULT_DW,
    parameter int DEPTH  = DEFAULT_DEPTH,
    parameter int NBANKS = DEFAULT_NBANKS
) (
    input  logic                         iclk,
    input  logic                         irst_n,
    output logic                         ofill_req,
    input  logic                         igen_we,
    input  logic [DW-1:0]                igen_data,
    output logic                         oready,
    output logic [$clog2(NBANKS+1)-1:0]  olevel,
    input  logic                         istart,
    input  logic                         ikeep,
    input  logic                         iraw_valid,
    input  logic [DW-1:0]                iraw_data,
    output logic                         oout_valid,
    output logic [DW-1:0]                oout_data,
    output logic                         oblock_done,
    output logic                         oerr
);

    localparam int AW = ptr_width(DEPTH);
    localparam int PW = ptr_width(NBANKS);
    localparam int LW = $clog2(NBANKS + 1);
    localparam logic [AW-1:0] LAST_WORD = AW'(DEPTH - 1);

    bank_state_e   r_state     [NBANKS];
    bank_state_e   w_state_nxt [NBANKS];
    logic [PW-1:0] r_fptr, r_rptr, w_fptr_nxt, w_rptr_nxt;
    logic [AW-1:0] r_waddr, r_raddr, w_waddr_nxt, w_raddr_nxt;

    logic          r_fill_req, r_ready;
    logic [LW-1:0] r_level;
    logic          w_fill_req_nxt, w_ready_nxt;
    logic [LW-1:0] w_level_nxt;

    logic          w_open, w_gen_ok, w_start_ok, w_rd_ok, w_last, w_err;
    logic          r_out_valid, r_block_done, r_err;
    logic [DW-1:0] r_raw, w_key;

    // Only the bank at rptr can ever be DRAINING, so it alone marks an open block.
    assign w_open     = (r_state[r_rptr] == BANK_DRAINING);
    assign w_gen_ok   = igen_we & r_fill_req;
    assign w_start_ok = istart & r_ready;
    assign w_rd_ok    = iraw_valid & w_open;
    assign w_last     = w_rd_ok & (r_raddr == LAST_WORD);
    assign w_err      = (igen_we & ~r_fill_req) | (istart & ~r_ready) | (iraw_valid & ~w_open);

    always_comb begin
        w_state_nxt = r_state;
        w_fptr_nxt  = r_fptr;
        w_rptr_nxt  = r_rptr;
        w_waddr_nxt = r_waddr;
        w_raddr_nxt = r_raddr;

        if (w_gen_ok) begin
            w_waddr_nxt = r_waddr + 1'b1;
            if (r_waddr == LAST_WORD) begin
                w_state_nxt[r_fptr] = BANK_READY;
                w_fptr_nxt          = r_fptr + 1'b1;
            end else begin
                w_state_nxt[r_fptr] = BANK_FILLING;
            end
        end

        if (w_start_ok) begin
            w_state_nxt[r_rptr] = BANK_DRAINING;
            w_raddr_nxt         = '0;
        end

        if (w_rd_ok) begin
            w_raddr_nxt = r_raddr + 1'b1;
            if (w_last) begin
                if (ikeep) begin
                    w_state_nxt[r_rptr] = BANK_READY;
                end else begin
                    w_state_nxt[r_rptr] = BANK_EMPTY;
                    w_rptr_nxt          = r_rptr + 1'b1;
                end
            end
        end
    end

    // Status flags are decoded from next state so they land one cycle after the cause.
    always_comb begin
        w_level_nxt = '0;
        for (int b = 0; b < NBANKS; b++) begin
            if (w_state_nxt[b] == BANK_READY) begin
                w_level_nxt = w_level_nxt + 1'b1;
            end
        end
        w_fill_req_nxt = (w_state_nxt[w_fptr_nxt] == BANK_EMPTY) ||
                         (w_state_nxt[w_fptr_nxt] == BANK_FILLING);
        w_ready_nxt    = (w_state_nxt[w_rptr_nxt] == BANK_READY);
    end

    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            for (int b = 0; b < NBANKS; b++) begin
                r_state[b] <= BANK_EMPTY;
            end
            r_fptr       <= '0;
            r_rptr       <= '0;
            r_waddr      <= '0;
            r_raddr      <= '0;
            r_fill_req   <= 1'b1;
            r_ready      <= 1'b0;
            r_level      <= '0;
            r_out_valid  <= 1'b0;
            r_block_done <= 1'b0;
            r_err        <= 1'b0;
            r_raw        <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_fptr       <= w_fptr_nxt;
            r_rptr       <= w_rptr_nxt;
            r_waddr      <= w_waddr_nxt;
            r_raddr      <= w_raddr_nxt;
            r_fill_req   <= w_fill_req_nxt;
            r_ready      <= w_ready_nxt;
            r_level      <= w_level_nxt;
            r_out_valid  <= w_rd_ok;
            r_block_done <= w_last;
            r_err        <= w_err;
            if (w_rd_ok) begin
                r_raw <= iraw_data;
            end
        end
    end

    sdp_ram #(
        .DW (DW),
        .AW (PW + AW)
    ) u_ram (
        .i_clk   (iclk),
        .i_we    (w_gen_ok),
        .i_waddr ({r_fptr, r_waddr}),
        .i_wdata (igen_data),
        .i_re    (w_rd_ok),
        .i_raddr ({r_rptr, r_raddr}),
        .o_rdata (w_key)
    );

    // The RAM read register is not reset, so the data bus is gated by valid.
    assign oout_data   = r_out_valid ? (r_raw ^ w_key) : '0;
    assign oout_valid  = r_out_valid;
    assign oblock_done = r_block_done;
    assign oerr        = r_err;
    assign ofill_req   = r_fill_req;
    assign oready      = r_ready;
    assign olevel      = r_level;

endmodule

// File: tb/tb_otp_stream_buffer.sv
// Directed bench for otp_stream_buffer with an XOR scoreboard fed at stimulus
// time and drained by an output monitor.
module tb_otp_stream_buffer;

    localparam int DW     = 4;
    localparam int DEPTH  = 1024;
    localparam int NBANKS = 2;

    logic       clk = 1'b0;
    logic       rstN;
    logic       fillReq;
    logic       genWe;
    logic [3:0] genData;
    logic       ready;
    logic [1:0] level;
    logic       start;
    logic       keep;
    logic       rawValid;
    logic [3:0] rawData;
    logic       outValid;
    logic [3:0] outData;
    logic       blockDone;
    logic       err;

    typedef struct packed {
        logic [3:0] data;
        logic       done;
    } sbEntry_t;

    sbEntry_t   sbQueue[$];
    sbEntry_t   monExp;
    logic [3:0] gModel [NBANKS][DEPTH];
    int         nCompared   = 0;
    int         nMismatched = 0;
    int         errSeen     = 0;

    otp_stream_buffer #(
        .DW     (DW),
        .DEPTH  (DEPTH),
        .NBANKS (NBANKS)
    ) dut (
        .iclk        (clk),
        .irst_n      (rstN),
        .ofill_req   (fillReq),
        .igen_we     (genWe),
        .igen_data   (genData),
        .oready      (ready),
        .olevel      (level),
        .istart      (start),
        .ikeep       (keep),
        .iraw_valid  (rawValid),
        .iraw_data   (rawData),
        .oout_valid  (outValid),
        .oout_data   (outData),
        .oblock_done (blockDone),
        .oerr        (err)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        nCompared++;
        assert (observed === expected) else begin
            nMismatched++;
            $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    function automatic logic [3:0] keyWord(input int mode, input int i);
        case (mode)
            0:       return 4'(i % 16);
            1:       return 4'((i * 7 + 3) % 16);
            2:       return 4'((i * 3 + 5) % 16);
            default: return 4'((i * 11 + 1) % 16);
        endcase
    endfunction

    // Drive one cycle of inputs just after a rising edge; return just after the next one.
    task automatic applyStimulus(input logic we, input logic [3:0] gd, input logic st,
                                 input logic kp, input logic rv, input logic [3:0] rd);
        genWe    = we;
        genData  = gd;
        start    = st;
        keep     = kp;
        rawValid = rv;
        rawData  = rd;
        @(posedge clk);
        #1;
        genWe    = 1'b0;
        start    = 1'b0;
        keep     = 1'b0;
        rawValid = 1'b0;
    endtask

    task automatic idleCycle();
        applyStimulus(1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 4'h0);
    endtask

    task automatic fillBank(input int bank, input int mode, input logic startOnLast, input logic checkReadyLow);
        logic [3:0] k;
        for (int i = 0; i < DEPTH; i++) begin
            k = keyWord(mode, i);
            gModel[bank][i] = k;
            if (i == 0 || i == DEPTH - 1) begin
                checkOutput("fill_req_during_fill", 32'(fillReq), 32'd1);
            end
            if (checkReadyLow && i == DEPTH - 1) begin
                checkOutput("ready_before_completion", 32'(ready), 32'd0);
            end
            applyStimulus(1'b1, k, startOnLast && (i == DEPTH - 1), 1'b0, 1'b0, 4'h0);
        end
    endtask

    task automatic drainBank(input int bank, input int nWords, input logic keepLast,
                             input int fillIdx, input int fillMode,
                             input logic useFixedRaw, input logic [3:0] fixedRaw);
        logic [3:0] raw;
        logic [3:0] k;
        for (int i = 0; i < nWords; i++) begin
            raw = useFixedRaw ? fixedRaw : 4'($urandom_range(15, 0));
            k   = 4'h0;
            sbQueue.push_back(sbEntry_t'{raw ^ gModel[bank][i], (i == DEPTH - 1)});
            if (fillIdx >= 0) begin
                k = keyWord(fillMode, i);
                gModel[fillIdx][i] = k;
            end
            applyStimulus(fillIdx >= 0, k, 1'b0, keepLast && (i == DEPTH - 1), 1'b1, raw);
            if (i == 0) begin
                checkOutput("read_latency", 32'(outValid), 32'd1);
            end
            if (i == DEPTH - 1) begin
                checkOutput("block_done_last", 32'(blockDone), 32'd1);
            end
        end
    endtask

    // Output monitor: every XOR result must match the oldest scoreboard entry.
    always @(negedge clk) begin
        if (rstN === 1'b1) begin
            if (err === 1'b1) begin
                errSeen++;
            end
            if (outValid === 1'b1) begin
                checkOutput("out_valid_expected", 32'(outValid), 32'(sbQueue.size() > 0));
                if (sbQueue.size() > 0) begin
                    monExp = sbQueue.pop_front();
                    checkOutput("xor_data", 32'(outData), 32'(monExp.data));
                    checkOutput("block_done", 32'(blockDone), 32'(monExp.done));
                end
            end else begin
                checkOutput("block_done_idle", 32'(blockDone), 32'd0);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: time limit reached, observed no finish, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int       errBase;
        sbEntry_t dropped;

        rstN     = 1'b0;
        genWe    = 1'b0;
        genData  = 4'h0;
        start    = 1'b0;
        keep     = 1'b0;
        rawValid = 1'b0;
        rawData  = 4'h0;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_fill_req", 32'(fillReq), 32'd1);
        checkOutput("reset_ready", 32'(ready), 32'd0);
        checkOutput("reset_level", 32'(level), 32'd0);
        checkOutput("reset_out_valid", 32'(outValid), 32'd0);
        checkOutput("reset_out_data", 32'(outData), 32'd0);
        checkOutput("reset_block_done", 32'(blockDone), 32'd0);
        checkOutput("reset_err", 32'(err), 32'd0);
        rstN = 1'b1;
        idleCycle();
        checkOutput("post_reset_fill_req", 32'(fillReq), 32'd1);
        checkOutput("post_reset_ready", 32'(ready), 32'd0);

        // Fill bank 0; an istart on the completing write must be rejected
        $display("[TB] fill bank 0");
        errBase = errSeen;
        fillBank(0, 0, 1'b1, 1'b1);
        checkOutput("fill_done_ready", 32'(ready), 32'd1);
        checkOutput("fill_done_level", 32'(level), 32'd1);
        checkOutput("fill_done_fill_req", 32'(fillReq), 32'd1);
        checkOutput("start_on_completion_err", 32'(err), 32'd1);
        idleCycle();
        checkOutput("start_on_completion_err_clear", 32'(err), 32'd0);
        checkOutput("start_on_completion_not_opened", 32'(ready), 32'd1);
        checkOutput("start_on_completion_err_count", 32'(errSeen - errBase), 32'd1);

        // Basic XOR with fixed raw 0xA
        $display("[TB] basic xor");
        errBase = errSeen;
        applyStimulus(1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 4'h0);
        checkOutput("open_ready", 32'(ready), 32'd0);
        checkOutput("open_level", 32'(level), 32'd0);
        drainBank(0, DEPTH, 1'b0, -1, 0, 1'b1, 4'hA);
        checkOutput("basic_level", 32'(level), 32'd0);
        checkOutput("basic_fill_req", 32'(fillReq), 32'd1);
        checkOutput("basic_ready", 32'(ready), 32'd0);
        idleCycle();
        checkOutput("basic_err_count", 32'(errSeen - errBase), 32'd0);

        // Overlap: fill one bank while draining the other, completions coincide
        $display("[TB] overlap");
        errBase = errSeen;
        fillBank(1, 1, 1'b0, 1'b1);
        applyStimulus(1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 4'h0);
        drainBank(1, DEPTH, 1'b0, 0, 2, 1'b0, 4'h0);
        checkOutput("overlap_level", 32'(level), 32'd1);
        checkOutput("overlap_ready", 32'(ready), 32'd1);
        checkOutput("overlap_fill_req", 32'(fillReq), 32'd1);
        idleCycle();
        checkOutput("overlap_err_count", 32'(errSeen - errBase), 32'd0);

        // Overfill: all banks READY, an extra word is dropped
        $display("[TB] overfill");
        fillBank(1, 3, 1'b0, 1'b0);
        checkOutput("full_level", 32'(level), 32'd2);
        checkOutput("full_fill_req", 32'(fillReq), 32'd0);
        errBase = errSeen;
        applyStimulus(1'b1, 4'hF, 1'b0, 1'b0, 1'b0, 4'h0);
        checkOutput("overfill_err", 32'(err), 32'd1);
        checkOutput("overfill_level", 32'(level), 32'd2);
        idleCycle();
        checkOutput("overfill_err_clear", 32'(err), 32'd0);
        checkOutput("overfill_err_count", 32'(errSeen - errBase), 32'd1);
        applyStimulus(1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 4'h0);
        drainBank(0, DEPTH, 1'b0, -1, 0, 1'b0, 4'h0);
        checkOutput("after_overfill_level", 32'(level), 32'd1);
        checkOutput("after_overfill_ready", 32'(ready), 32'd1);
        checkOutput("after_overfill_fill_req", 32'(fillReq), 32'd1);

        // Retry: keep twice, then release
        $display("[TB] retry");
        applyStimulus(1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 4'h0);
        drainBank(1, DEPTH, 1'b1, -1, 0, 1'b0, 4'h0);
        checkOutput("keep1_level", 32'(level), 32'd1);
        checkOutput("keep1_ready", 32'(ready), 32'd1);
        applyStimulus(1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 4'h0);
        drainBank(1, DEPTH, 1'b1, -1, 0, 1'b1, 4'h0);
        checkOutput("keep2_level", 32'(level), 32'd1);
        checkOutput("keep2_ready", 32'(ready), 32'd1);
        applyStimulus(1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 4'h0);
        drainBank(1, DEPTH, 1'b0, -1, 0, 1'b0, 4'h0);
        checkOutput("release_level", 32'(level), 32'd0);
        checkOutput("release_ready", 32'(ready), 32'd0);
        checkOutput("release_fill_req", 32'(fillReq), 32'd1);

        // Abort mid-block at raddr=500 while an output word is on the bus
        $display("[TB] abort");
        fillBank(0, 0, 1'b0, 1'b1);
        applyStimulus(1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 4'h0);
        drainBank(0, 500, 1'b0, -1, 0, 1'b0, 4'h0);
        checkOutput("abort_valid_before", 32'(outValid), 32'd1);
        rstN = 1'b0;
        #1;
        dropped = sbQueue.pop_back();
        checkOutput("abort_fill_req", 32'(fillReq), 32'd1);
        checkOutput("abort_ready", 32'(ready), 32'd0);
        checkOutput("abort_level", 32'(level), 32'd0);
        checkOutput("abort_out_valid", 32'(outValid), 32'd0);
        checkOutput("abort_out_data", 32'(outData), 32'd0);
        checkOutput("abort_block_done", 32'(blockDone), 32'd0);
        checkOutput("abort_err", 32'(err), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rstN = 1'b1;
        idleCycle();
        checkOutput("abort_release_ready", 32'(ready), 32'd0);
        checkOutput("abort_release_level", 32'(level), 32'd0);
        checkOutput("abort_release_fill_req", 32'(fillReq), 32'd1);

        // Protocol errors with nothing ready or open
        $display("[TB] protocol errors");
        errBase = errSeen;
        applyStimulus(1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 4'h0);
        checkOutput("bad_start_err", 32'(err), 32'd1);
        checkOutput("bad_start_no_valid", 32'(outValid), 32'd0);
        idleCycle();
        checkOutput("bad_start_err_clear", 32'(err), 32'd0);
        applyStimulus(1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 4'h5);
        checkOutput("bad_raw_err", 32'(err), 32'd1);
        checkOutput("bad_raw_no_valid", 32'(outValid), 32'd0);
        idleCycle();
        checkOutput("bad_raw_err_clear", 32'(err), 32'd0);
        checkOutput("bad_raw_no_valid_later", 32'(outValid), 32'd0);
        checkOutput("protocol_err_count", 32'(errSeen - errBase), 32'd2);

        idleCycle();
        idleCycle();
        checkOutput("scoreboard_drained", 32'(sbQueue.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
